// File: rtl/tx_scheduler.sv
// Transmit scheduler: per-client one-deep pending slots, a round-robin arbiter that
// feeds a grant queue, and a grant FSM that handshakes with the transmitter busy flag.
module tx_scheduler #(
    parameter int unsigned  NREQ    = 4,
    parameter int unsigned  CW      = 16,
    parameter int unsigned  AW      = 3,
    parameter int unsigned  TIMEOUT = 255,
    localparam int unsigned IW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ*CW-1:0] reqcode_i,
    output logic [NREQ-1:0]    reqacpt_o,
    input  logic               tx_busy_i,
    output logic               ack_o,
    output logic [CW-1:0]      ackcode_o,
    output logic [NREQ-1:0]    ackgrant_o,
    output logic [IW-1:0]      sel_o,
    output logic [AW:0]        qcnt_o,
    output logic               overflow_o,
    output logic               timeout_err_o
);

    localparam int unsigned Depth = 2 ** AW;
    localparam int unsigned TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StAck, StWaitBusy, StSend} state_e;

    state_e              state_q;
    logic [NREQ-1:0]     pend_q, pend_d, picked;
    logic [CW-1:0]       pcode_q [NREQ];
    logic [IW-1:0]       last_q, pick_idx;
    logic                pick_found;
    int unsigned         arb_idx;
    logic                overflow_q;

    logic [IW+CW-1:0]    mem_q [Depth];
    logic [AW-1:0]       wptr_q, rptr_q;
    logic [AW:0]         cnt_q;
    logic                full, push, pop;
    logic [IW-1:0]       head_idx;
    logic [CW-1:0]       head_code;

    logic                ack_q;
    logic [NREQ-1:0]     ackgrant_q;
    logic [CW-1:0]       ackcode_q;
    logic [IW-1:0]       sel_q;
    logic [TW-1:0]       tmo_q;
    logic                terr_q;

    // Round-robin search for the first pending client after the last one picked.
    always_comb begin
        pick_idx   = last_q;
        pick_found = 1'b0;
        arb_idx    = 0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            arb_idx = (int'(last_q) + k) % NREQ;
            if (!pick_found && pend_q[IW'(arb_idx)]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(arb_idx);
            end
        end
    end

    // Acceptance, pick and queue handshake; a picked slot can be refilled in the same cycle.
    always_comb begin
        full      = (cnt_q == (AW+1)'(Depth));
        push      = pick_found && !full;
        picked    = push ? (NREQ'(1) << pick_idx) : '0;
        reqacpt_o = req_i & (~pend_q | picked);
        pend_d    = (pend_q & ~picked) | reqacpt_o;
        pop       = (state_q == StIdle) && (cnt_q != '0) && !tx_busy_i;
        head_idx  = mem_q[rptr_q][IW+CW-1:CW];
        head_code = mem_q[rptr_q][CW-1:0];
    end

    // Pending slots, captured codes, round-robin pointer and sticky overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q     <= '0;
            last_q     <= IW'(NREQ - 1);
            overflow_q <= 1'b0;
            for (int i = 0; i < int'(NREQ); i++) pcode_q[i] <= '0;
        end else begin
            pend_q <= pend_d;
            if (push) last_q <= pick_idx;
            if (|(req_i & ~reqacpt_o)) overflow_q <= 1'b1;
            for (int i = 0; i < int'(NREQ); i++) begin
                if (reqacpt_o[i]) pcode_q[i] <= reqcode_i[i*CW +: CW];
            end
        end
    end

    // Grant queue storage; contents are don't-care whenever the count says empty.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= {pick_idx, pcode_q[pick_idx]};
    end

    // Grant queue pointers and occupancy; simultaneous push and pop keeps the count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Grant FSM with registered ack outputs and busy-rise timeout.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            ack_q      <= 1'b0;
            ackgrant_q <= '0;
            ackcode_q  <= '0;
            sel_q      <= '0;
            tmo_q      <= '0;
            terr_q     <= 1'b0;
        end else begin
            ack_q      <= 1'b0;
            ackgrant_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        state_q    <= StAck;
                        ack_q      <= 1'b1;
                        ackgrant_q <= NREQ'(1) << head_idx;
                        ackcode_q  <= head_code;
                        sel_q      <= head_idx;
                    end
                end
                StAck: begin
                    state_q <= StWaitBusy;
                    tmo_q   <= '0;
                end
                StWaitBusy: begin
                    if (tx_busy_i) begin
                        state_q <= StSend;
                    end else if (tmo_q == TW'(TIMEOUT)) begin
                        terr_q  <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                StSend: begin
                    if (!tx_busy_i) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ack_o         = ack_q;
    assign ackgrant_o    = ackgrant_q;
    assign ackcode_o     = ackcode_q;
    assign sel_o         = sel_q;
    assign qcnt_o        = cnt_q;
    assign overflow_o    = overflow_q;
    assign timeout_err_o = terr_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed bench for tx_scheduler with hand-computed expectations.
module tb_tx_scheduler;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned CW      = 16;
    localparam int unsigned AW      = 3;
    localparam int unsigned TIMEOUT = 255;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] reqcode;
    logic [NREQ-1:0]    reqacpt;
    logic               tx_busy;
    logic               ack;
    logic [CW-1:0]      ackcode;
    logic [NREQ-1:0]    ackgrant;
    logic [1:0]         sel;
    logic [AW:0]        qcnt;
    logic               overflow;
    logic               timeout_err;

    int ntests = 0;
    int nfail  = 0;

    tx_scheduler #(
        .NREQ    (NREQ),
        .CW      (CW),
        .AW      (AW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_i         (req),
        .reqcode_i     (reqcode),
        .reqacpt_o     (reqacpt),
        .tx_busy_i     (tx_busy),
        .ack_o         (ack),
        .ackcode_o     (ackcode),
        .ackgrant_o    (ackgrant),
        .sel_o         (sel),
        .qcnt_o        (qcnt),
        .overflow_o    (overflow),
        .timeout_err_o (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_code(input int i, input logic [CW-1:0] v);
        reqcode[i*CW +: CW] = v;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = '0;
        tx_busy = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Polls for ack for at most bound cycles, leaving time on the ack cycle if seen.
    task automatic wait_ack(input int bound, output bit got);
        got = 1'b0;
        for (int n = 0; n < bound; n++) begin
            if (ack === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Called on the ack cycle: raise busy in WAIT_BUSY, hold two cycles, drop it.
    task automatic serve();
        tick();
        tx_busy = 1'b1;
        tick();
        tick();
        tx_busy = 1'b0;
    endtask

    logic [NREQ-1:0] exp_g [10];
    logic [CW-1:0]   exp_c [10];
    bit              got;

    initial begin
        req     = '0;
        reqcode = '0;
        tx_busy = 1'b0;
        rst_n   = 1'b0;
        tick();
        tick();
        check("rst_qcnt", 32'(qcnt), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_ackgrant", 32'(ackgrant), 32'h0);
        check("rst_ackcode", 32'(ackcode), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_timeout", 32'(timeout_err), 32'h0);
        rst_n = 1'b1;
        tick();

        // Single request: ack three cycles later.
        req = 4'b0001;
        set_code(0, 16'h0800);
        #1;
        check("single_acpt", 32'(reqacpt), 32'h1);
        tick();
        req = '0;
        check("single_c1_ack", 32'(ack), 32'h0);
        tick();
        check("single_c2_qcnt", 32'(qcnt), 32'h1);
        check("single_c2_ack", 32'(ack), 32'h0);
        tick();
        check("single_c3_ack", 32'(ack), 32'h1);
        check("single_ackcode", 32'(ackcode), 32'h0800);
        check("single_ackgrant", 32'(ackgrant), 32'h1);
        check("single_sel", 32'(sel), 32'h0);
        tick();
        check("single_ack_pulse", 32'(ack), 32'h0);
        tx_busy = 1'b1;
        for (int n = 0; n < 10; n++) tick();
        tx_busy = 1'b0;
        tick();
        tick();
        check("single_no_timeout", 32'(timeout_err), 32'h0);
        check("single_qcnt_end", 32'(qcnt), 32'h0);

        // All four clients at once after a fresh reset.
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 4; i++) set_code(i, 16'(16'h00A0 + i));
        #1;
        check("all_acpt", 32'(reqacpt), 32'hF);
        tick();
        req = '0;
        check("all_c1_qcnt", 32'(qcnt), 32'h0);
        check("all_overflow", 32'(overflow), 32'h0);
        tick();
        check("all_c2_qcnt", 32'(qcnt), 32'h1);
        tick();
        check("all_c3_qcnt_pushpop", 32'(qcnt), 32'h1);
        for (int i = 0; i < 4; i++) begin
            wait_ack(30, got);
            check("all_ack_seen", 32'(got), 32'h1);
            check("all_ackgrant", 32'(ackgrant), 32'(4'b0001 << i));
            check("all_ackcode", 32'(ackcode), 32'(16'h00A0 + i));
            check("all_sel", 32'(sel), 32'(i));
            serve();
        end
        wait_ack(15, got);
        check("all_no_extra_ack", 32'(got), 32'h0);
        check("all_overflow_end", 32'(overflow), 32'h0);

        // Fill the queue with busy high, then overflow client 2 while it is pending.
        do_reset();
        tx_busy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req = 4'(4'b0001 << (k % 4));
            set_code(k % 4, 16'(16'h0100 + k));
            tick();
        end
        req = '0;
        tick();
        check("fill_qcnt_full", 32'(qcnt), 32'h8);
        req = 4'b0100;
        set_code(2, 16'h0222);
        #1;
        check("fill_acpt_c2_first", 32'(reqacpt), 32'h4);
        tick();
        req = 4'b1100;
        set_code(2, 16'h0333);
        set_code(3, 16'h0555);
        #1;
        check("fill_acpt_c2_second", 32'(reqacpt), 32'h8);
        check("fill_overflow_before", 32'(overflow), 32'h0);
        tick();
        req = '0;
        check("fill_overflow", 32'(overflow), 32'h1);
        check("fill_qcnt_held", 32'(qcnt), 32'h8);
        wait_ack(6, got);
        check("fill_no_ack", 32'(got), 32'h0);
        check("fill_qcnt_held2", 32'(qcnt), 32'h8);
        for (int k = 0; k < 8; k++) begin
            exp_g[k] = 4'(4'b0001 << (k % 4));
            exp_c[k] = 16'(16'h0100 + k);
        end
        exp_g[8] = 4'b0100;
        exp_c[8] = 16'h0222;
        exp_g[9] = 4'b1000;
        exp_c[9] = 16'h0555;
        tx_busy = 1'b0;
        for (int k = 0; k < 10; k++) begin
            wait_ack(30, got);
            check("drain_ack_seen", 32'(got), 32'h1);
            check("drain_ackgrant", 32'(ackgrant), 32'(exp_g[k]));
            check("drain_ackcode", 32'(ackcode), 32'(exp_c[k]));
            serve();
        end
        wait_ack(15, got);
        check("drain_no_extra_ack", 32'(got), 32'h0);
        check("drain_qcnt_empty", 32'(qcnt), 32'h0);

        // Timeout: busy never rises after the first grant.
        do_reset();
        req = 4'b0011;
        set_code(0, 16'h00C0);
        set_code(1, 16'h00C1);
        tick();
        req = '0;
        wait_ack(10, got);
        check("tmo_first_ack", 32'(got), 32'h1);
        check("tmo_first_grant", 32'(ackgrant), 32'h1);
        for (int n = 0; n < int'(TIMEOUT) + 1; n++) tick();
        check("tmo_err_not_yet", 32'(timeout_err), 32'h0);
        tick();
        check("tmo_err_set", 32'(timeout_err), 32'h1);
        check("tmo_no_ack_yet", 32'(ack), 32'h0);
        tick();
        check("tmo_next_ack", 32'(ack), 32'h1);
        check("tmo_next_grant", 32'(ackgrant), 32'h2);
        check("tmo_next_code", 32'(ackcode), 32'h00C1);
        serve();
        tick();
        check("tmo_err_sticky", 32'(timeout_err), 32'h1);

        // Reset while in SEND with three grants still queued.
        do_reset();
        req = 4'b0010;
        set_code(1, 16'h0011);
        tick();
        req = 4'b0100;
        set_code(2, 16'h0022);
        tick();
        req = 4'b1000;
        set_code(3, 16'h0033);
        tick();
        req = 4'b0001;
        set_code(0, 16'h0044);
        check("mid_ack", 32'(ack), 32'h1);
        check("mid_sel", 32'(sel), 32'h1);
        tick();
        req     = '0;
        tx_busy = 1'b1;
        tick();
        tick();
        check("mid_qcnt3", 32'(qcnt), 32'h3);
        check("mid_sel_held", 32'(sel), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_qcnt", 32'(qcnt), 32'h0);
        check("mid_rst_ack", 32'(ack), 32'h0);
        check("mid_rst_ackcode", 32'(ackcode), 32'h0);
        check("mid_rst_ackgrant", 32'(ackgrant), 32'h0);
        check("mid_rst_sel", 32'(sel), 32'h0);
        check("mid_rst_acpt", 32'(reqacpt), 32'h0);
        check("mid_rst_flags", 32'({overflow, timeout_err}), 32'h0);
        tick();
        tx_busy = 1'b0;
        rst_n   = 1'b1;
        wait_ack(20, got);
        check("mid_post_no_ack", 32'(got), 32'h0);
        req = 4'b0100;
        set_code(2, 16'h0777);
        tick();
        req = '0;
        wait_ack(10, got);
        check("mid_new_ack", 32'(got), 32'h1);
        check("mid_new_grant", 32'(ackgrant), 32'h4);
        check("mid_new_code", 32'(ackcode), 32'h0777);
        serve();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
